// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch->decode handoff.
// master = fetch_unit side, slave = memory/decode environment side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_instr, id_pc, id_fault,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_instr, id_pc, id_fault,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem request, fetch buffer of DEPTH entries,
// drives program_counter hold/redirect and flags misaligned PCs as faults.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        pc_we_o,
    output logic [31:0] pc_next_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            outstanding, drop, halt;
    logic [31:0]     inflight_pc;

    logic            misaligned, credit_ok, can_issue, grant, rsp;
    logic            rsp_push, flt_push, pop;
    logic [1:0]      n_push;

    // Credit counts buffered plus in-flight words so a response always has a slot.
    assign misaligned = |pc_i[1:0];
    assign credit_ok  = (count + CW'(outstanding)) < CW'(DEPTH);
    assign can_issue  = !rst_i && !redirect_i && !halt
                        && (!outstanding || bus.imem_rvalid) && credit_ok;

    assign bus.imem_req  = can_issue && !misaligned;
    assign bus.imem_addr = pc_i;

    assign grant    = bus.imem_req && bus.imem_gnt;
    assign rsp      = outstanding && bus.imem_rvalid;
    assign rsp_push = rsp && !drop && !redirect_i;
    assign flt_push = can_issue && misaligned;
    assign pop      = bus.id_valid && bus.id_ready && !redirect_i;
    assign n_push   = {1'b0, rsp_push} + {1'b0, flt_push};

    always_comb begin
        pc_we_o   = 1'b1;
        pc_next_o = pc_i;
        if (!rst_i) begin
            if (redirect_i)
                pc_next_o = redirect_addr_i;
            else if (grant)
                pc_we_o = 1'b0;
        end
    end

    assign bus.id_valid = (count != '0);
    assign bus.id_instr = mem[rd_ptr].instr;
    assign bus.id_pc    = mem[rd_ptr].pc;
    assign bus.id_fault = mem[rd_ptr].fault;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            halt        <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                inflight_pc <= pc_i;
            end else if (rsp) begin
                outstanding <= 1'b0;
            end

            // A flushed request still owes us one word; swallow it when it lands.
            if (rsp)
                drop <= 1'b0;
            else if (redirect_i && outstanding)
                drop <= 1'b1;

            if (redirect_i)
                halt <= 1'b0;
            else if (flt_push)
                halt <= 1'b1;

            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(n_push);
                rd_ptr <= rd_ptr + AW'(pop);
                count  <= count + CW'(n_push) - CW'(pop);
            end
        end
    end

    // A response and a fault can land together; the response is older.
    always_ff @(posedge clk_i) begin
        if (rsp_push)
            mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: inflight_pc, fault: 1'b0};
        if (flt_push)
            mem[wr_ptr + AW'(rsp_push)] <= '{instr: 32'h0, pc: pc_i, fault: 1'b1};
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        redirect_i || (int'(count) + int'(n_push) <= DEPTH + int'(pop)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency memory, program_counter model and an
// in-order delivery model (consecutive PCs from each redirect target).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_we_o(pc_we), .pc_next_o(pc_next),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) pc <= '0;
        else     pc <= pc_we ? pc_next : pc + 32'd4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2] ^ 16'hBEEF, a[17:2] + 16'h1234};
    endfunction

    logic        gnt_auto = 1'b0;
    logic        man_gnt  = 1'b0;
    int          gnt_prob = 100;
    int          lat_min  = 0;
    int          lat_max  = 0;

    logic [31:0] pend_addr[$];
    int          pend_dly[$];

    int          n_acc = 0;
    logic [31:0] exp_pc = '0;
    logic        exp_halt = 1'b0;
    logic [31:0] last_pc = '0, last_instr = '0;
    logic        last_fault = 1'b0;

    // Memory responder and delivery model share one process per cycle.
    always begin
        logic        ef;
        logic [31:0] ei;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        if (pend_addr.size() > 0) begin
            if (pend_dly[0] == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_dly.pop_front());
            end else begin
                pend_dly[0] = pend_dly[0] - 1;
            end
        end
        #1;
        bus.imem_gnt = gnt_auto ? ($urandom_range(99, 0) < gnt_prob) : man_gnt;
        #2;
        if (rst) begin
            exp_pc   = '0;
            exp_halt = 1'b0;
        end else begin
            if (bus.imem_req && bus.imem_gnt) begin
                checks++;
                if (pc_we !== 1'b0 || bus.imem_addr !== pc || pc[1:0] !== 2'b00) begin
                    errors++;
                    $display("FAIL grant_ctl: pc_we=%0b addr=%h pc=%h, required pc_we=0 addr=pc aligned",
                             pc_we, bus.imem_addr, pc);
                end
                pend_addr.push_back(bus.imem_addr);
                pend_dly.push_back($urandom_range(lat_max, lat_min));
            end else if (bus.imem_req) begin
                checks++;
                if (pc_we !== 1'b1 || pc_next !== pc || bus.imem_addr !== pc) begin
                    errors++;
                    $display("FAIL hold_ctl: pc_we=%0b pc_next=%h addr=%h, required 1/%h/%h",
                             pc_we, pc_next, bus.imem_addr, pc, pc);
                end
            end
            if (redirect) begin
                checks++;
                if (bus.imem_req !== 1'b0 || pc_we !== 1'b1 || pc_next !== redirect_addr) begin
                    errors++;
                    $display("FAIL redirect_ctl: req=%0b pc_we=%0b pc_next=%h, required 0/1/%h",
                             bus.imem_req, pc_we, pc_next, redirect_addr);
                end
                exp_pc   = redirect_addr;
                exp_halt = 1'b0;
            end else if (bus.id_valid && bus.id_ready) begin
                ef = (exp_pc[1:0] != 2'b00);
                ei = ef ? 32'h0 : mem_word(exp_pc);
                checks++;
                if (bus.id_pc !== exp_pc || bus.id_instr !== ei || bus.id_fault !== ef || exp_halt) begin
                    errors++;
                    $display("FAIL deliver: pc=%h instr=%h fault=%0b, required pc=%h instr=%h fault=%0b halted=%0b",
                             bus.id_pc, bus.id_instr, bus.id_fault, exp_pc, ei, ef, exp_halt);
                end
                last_pc    = bus.id_pc;
                last_instr = bus.id_instr;
                last_fault = bus.id_fault;
                n_acc++;
                if (ef) exp_halt = 1'b1;
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic wait_acc(input int target, input int budget, output bit ok);
        int i = 0;
        while (n_acc < target && i < budget) begin
            @(negedge clk); #4;
            i++;
        end
        ok = (n_acc >= target);
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.id_ready = 1'b1; gnt_auto = 1'b0; man_gnt = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %0b, required 0", bus.id_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: %0b, required 0", bus.imem_req); end
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL reset_pc_we: %0b, required 1", pc_we); end
        checks++; if (pc_next !== pc) begin errors++; $display("FAIL reset_pc_next: %h, required %h", pc_next, pc); end
        @(negedge clk);
        man_gnt = 1'b0; rst = 1'b0;
    endtask

    task automatic test_stream;
        bit ok;
        int b;
        @(negedge clk);
        gnt_auto = 1'b1; gnt_prob = 100; lat_min = 0; lat_max = 0;
        b = n_acc;
        wait_acc(b + 4, 20, ok);
        checks++;
        if (!ok || last_pc !== 32'hC) begin
            errors++; $display("FAIL stream: delivered=%0d last_pc=%h, required 4 / 0000000c", n_acc - b, last_pc);
        end
    endtask

    task automatic test_gnt_stall;
        bit ok;
        int b;
        @(negedge clk);
        gnt_auto = 1'b0; man_gnt = 1'b0; redirect = 1'b1; redirect_addr = 32'h8;
        @(negedge clk);
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #4;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || pc_we !== 1'b1 || pc_next !== 32'h8) begin
                errors++;
                $display("FAIL gnt_stall: req=%0b addr=%h pc_we=%0b pc_next=%h, required 1/8/1/8",
                         bus.imem_req, bus.imem_addr, pc_we, pc_next);
            end
        end
        @(negedge clk); man_gnt = 1'b1; #4;
        checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL gnt_advance: pc_we=%0b, required 0", pc_we); end
        @(negedge clk); man_gnt = 1'b0; #4;
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL gnt_pc: pc=%h, required 0000000c", pc); end
        gnt_auto = 1'b1;
        b = n_acc;
        wait_acc(b + 3, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gnt_resume: delivered=%0d, required 3", n_acc - b); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int b;
        logic [31:0] p, ipc, iins;
        @(negedge clk);
        bus.id_ready = 1'b0;
        repeat (8) @(negedge clk);
        #4;
        p = pc; ipc = bus.id_pc; iins = bus.id_instr;
        checks++;
        if (bus.id_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_full: valid=%0b req=%0b, required 1/0", bus.id_valid, bus.imem_req);
        end
        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (pc !== p || bus.id_pc !== ipc || bus.id_instr !== iins || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_hold: pc=%h id_pc=%h instr=%h req=%0b, required %h/%h/%h/0",
                               pc, bus.id_pc, bus.id_instr, bus.imem_req, p, ipc, iins);
        end
        @(negedge clk);
        bus.id_ready = 1'b1;
        b = n_acc;
        wait_acc(b + 4, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_resume: delivered=%0d, required 4", n_acc - b); end
    endtask

    task automatic test_redirect_flush;
        bit ok;
        int b;
        @(negedge clk);
        gnt_auto = 1'b0; man_gnt = 1'b0; lat_min = 1; lat_max = 1;
        redirect = 1'b1; redirect_addr = 32'h10;
        @(negedge clk);
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); man_gnt = 1'b1; #4;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            errors++; $display("FAIL flush_req: req=%0b addr=%h, required 1/00000010", bus.imem_req, bus.imem_addr);
        end
        @(negedge clk); man_gnt = 1'b0; redirect = 1'b1; redirect_addr = 32'h100; #4;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL flush_noreq: req=%0b, required 0", bus.imem_req); end
        @(negedge clk); redirect = 1'b0; #4;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: valid=%0b, required 0", bus.id_valid); end
        @(negedge clk); #4;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: valid=%0b, required 0", bus.id_valid); end
        lat_min = 0; lat_max = 0; gnt_auto = 1'b1;
        b = n_acc;
        wait_acc(b + 1, 20, ok);
        checks++;
        if (!ok || last_pc !== 32'h100) begin
            errors++; $display("FAIL flush_target: last_pc=%h, required 00000100", last_pc);
        end
    endtask

    task automatic test_misaligned;
        bit ok;
        int b, bad;
        @(negedge clk);
        redirect = 1'b1; redirect_addr = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        b = n_acc;
        wait_acc(b + 1, 10, ok);
        checks++;
        if (!ok || last_fault !== 1'b1 || last_pc !== 32'h102 || last_instr !== 32'h0) begin
            errors++; $display("FAIL misalign_fault: fault=%0b pc=%h instr=%h, required 1/00000102/0",
                               last_fault, last_pc, last_instr);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk); #4;
            if (bus.imem_req !== 1'b0 || pc !== 32'h102) bad++;
        end
        checks++;
        if (bad != 0 || n_acc != b + 1) begin
            errors++; $display("FAIL misalign_halt: bad_cycles=%0d extra=%0d, required 0/0", bad, n_acc - b - 1);
        end
        @(negedge clk); redirect = 1'b1; redirect_addr = 32'h200;
        @(negedge clk); redirect = 1'b0;
        b = n_acc;
        wait_acc(b + 2, 20, ok);
        checks++;
        if (!ok || last_pc !== 32'h204) begin
            errors++; $display("FAIL misalign_resume: last_pc=%h, required 00000204", last_pc);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, found;
        int b;
        @(negedge clk);
        bus.id_ready = 1'b0; lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #4;
            found = (pend_addr.size() > 0) && bus.id_valid;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_setup: no in-flight request with buffered word"); end
        @(negedge clk);
        gnt_auto = 1'b0; man_gnt = 1'b0;
        #2 rst = 1'b1;
        #2;
        checks++;
        if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0 || pc_we !== 1'b1) begin
            errors++; $display("FAIL rst_async: valid=%0b req=%0b pc_we=%0b, required 0/0/1",
                               bus.id_valid, bus.imem_req, pc_we);
        end
        @(negedge clk);
        rst = 1'b0; bus.id_ready = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() > 0; i++) @(negedge clk);
        @(negedge clk); #4;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid: valid=%0b, required 0", bus.id_valid); end
        lat_min = 0; lat_max = 0; gnt_auto = 1'b1;
        b = n_acc;
        wait_acc(b + 2, 20, ok);
        checks++;
        if (!ok || last_pc !== 32'h4) begin
            errors++; $display("FAIL rst_restart: last_pc=%h, required 00000004", last_pc);
        end
    endtask

    task automatic test_random;
        int b;
        logic [7:0] r;
        @(negedge clk);
        gnt_prob = 60; lat_min = 0; lat_max = 3;
        b = n_acc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.id_ready = ($urandom_range(3, 0) != 0);
            redirect = ($urandom_range(29, 0) == 0);
            if (redirect) begin
                r = 8'($urandom_range(255, 0));
                redirect_addr = {22'h0, r, 2'b00} + (($urandom_range(3, 0) == 0) ? 32'd2 : 32'd0);
            end
        end
        @(negedge clk);
        redirect = 1'b0; bus.id_ready = 1'b1;
        checks++;
        if (n_acc - b < 20) begin errors++; $display("FAIL random_progress: delivered=%0d, required >=20", n_acc - b); end
    endtask

    initial begin
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1;
        test_reset;
        test_stream;
        test_gnt_stall;
        test_backpressure;
        test_redirect_flush;
        test_misaligned;
        test_reset_mid;
        test_random;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
